// File: rtl/regfile_access_ctrl.sv
// Host-side command master for the 32x32 register file: sequences single writes, dual-port reads
// and a write-then-verify self-test sweep, returning one response per accepted command.
module regfile_access_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              rf_writeEn,
    output logic [ADDR_W-1:0] rf_writeReg,
    output logic [DATA_W-1:0] rf_writeData,
    output logic [ADDR_W-1:0] rf_readRegA,
    output logic [ADDR_W-1:0] rf_readRegB,
    input  logic [DATA_W-1:0] rf_readDataA,
    input  logic [DATA_W-1:0] rf_readDataB
);

    localparam int                CNT_W    = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        BIST_WR = 3'd3,
        BIST_RD = 3'd4,
        RESP    = 3'd5
    } stateT;

    stateT              stateR, stateNextS;
    logic [ADDR_W-1:0]  idxR, idxNextS;
    logic [CNT_W-1:0]   errCntR, errCntNextS, errCntSumS;
    logic [DATA_W-1:0]  seedR, seedNextS, expS;
    logic               cmdReadyR, cmdReadyNextS;
    logic               rspValidR, rspValidNextS;
    logic [DATA_W-1:0]  rspDataR, rspDataNextS;
    logic               rspErrR, rspErrNextS;
    logic               writeEnR, writeEnNextS;
    logic [ADDR_W-1:0]  writeRegR, writeRegNextS;
    logic [DATA_W-1:0]  writeDataR, writeDataNextS;
    logic [ADDR_W-1:0]  readRegR, readRegNextS;
    logic               acceptS;

    function automatic logic [DATA_W-1:0] bistPattern(input logic [DATA_W-1:0] seed,
                                                      input logic [ADDR_W-1:0] idx);
        return seed ^ DATA_W'(idx);
    endfunction

    function automatic logic [1:0] mismatchCount(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] exp);
        return {1'b0, (a != exp)} + {1'b0, (b != exp)};
    endfunction

    // The error counter saturates instead of wrapping so a badly broken array never reads as clean.
    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // FSM state register
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Next-state and next-output decode; every output is computed one cycle ahead and registered
    always_comb begin
        stateNextS     = stateR;
        idxNextS       = idxR;
        errCntNextS    = errCntR;
        seedNextS      = seedR;
        rspDataNextS   = rspDataR;
        rspErrNextS    = rspErrR;
        writeEnNextS   = 1'b0;
        writeRegNextS  = writeRegR;
        writeDataNextS = writeDataR;
        readRegNextS   = readRegR;
        acceptS        = cmd_valid & cmdReadyR;
        expS           = bistPattern(seedR, idxR);
        errCntSumS     = satAdd(errCntR, mismatchCount(rf_readDataA, rf_readDataB, expS));

        case (stateR)
            IDLE: begin
                if (acceptS) begin
                    seedNextS = cmd_data;
                    case (cmd_op)
                        2'b00: begin
                            stateNextS     = WRITE;
                            writeEnNextS   = 1'b1;
                            writeRegNextS  = cmd_addr;
                            writeDataNextS = cmd_data;
                        end
                        2'b01: begin
                            stateNextS   = READ;
                            readRegNextS = cmd_addr;
                        end
                        2'b10: begin
                            stateNextS     = BIST_WR;
                            idxNextS       = {ADDR_W{1'b0}};
                            errCntNextS    = {CNT_W{1'b0}};
                            writeEnNextS   = 1'b1;
                            writeRegNextS  = {ADDR_W{1'b0}};
                            writeDataNextS = bistPattern(cmd_data, {ADDR_W{1'b0}});
                        end
                        default: begin
                            stateNextS   = RESP;
                            rspDataNextS = {DATA_W{1'b0}};
                            rspErrNextS  = 1'b1;
                        end
                    endcase
                end else begin
                    stateNextS = IDLE;
                end
            end
            WRITE: begin
                stateNextS   = RESP;
                rspDataNextS = writeDataR;
                rspErrNextS  = 1'b0;
            end
            READ: begin
                stateNextS   = RESP;
                rspDataNextS = rf_readDataA;
                rspErrNextS  = (rf_readDataA != rf_readDataB);
            end
            BIST_WR: begin
                if (idxR == LAST_IDX) begin
                    stateNextS   = BIST_RD;
                    idxNextS     = {ADDR_W{1'b0}};
                    readRegNextS = {ADDR_W{1'b0}};
                end else begin
                    idxNextS       = idxR + IDX_ONE;
                    writeEnNextS   = 1'b1;
                    writeRegNextS  = idxR + IDX_ONE;
                    writeDataNextS = bistPattern(seedR, idxR + IDX_ONE);
                end
            end
            BIST_RD: begin
                errCntNextS = errCntSumS;
                if (idxR == LAST_IDX) begin
                    stateNextS   = RESP;
                    rspDataNextS = DATA_W'(errCntSumS);
                    rspErrNextS  = (errCntSumS != {CNT_W{1'b0}});
                end else begin
                    idxNextS     = idxR + IDX_ONE;
                    readRegNextS = idxR + IDX_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNextS = IDLE;
                end else begin
                    stateNextS = RESP;
                end
            end
            default: begin
                stateNextS = IDLE;
            end
        endcase

        cmdReadyNextS = (stateNextS == IDLE);
        rspValidNextS = (stateNextS == RESP);
    end

    // Datapath and output registers; reset aborts any in-flight command without a response
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            idxR       <= {ADDR_W{1'b0}};
            errCntR    <= {CNT_W{1'b0}};
            seedR      <= {DATA_W{1'b0}};
            cmdReadyR  <= 1'b0;
            rspValidR  <= 1'b0;
            rspDataR   <= {DATA_W{1'b0}};
            rspErrR    <= 1'b0;
            writeEnR   <= 1'b0;
            writeRegR  <= {ADDR_W{1'b0}};
            writeDataR <= {DATA_W{1'b0}};
            readRegR   <= {ADDR_W{1'b0}};
        end else begin
            idxR       <= idxNextS;
            errCntR    <= errCntNextS;
            seedR      <= seedNextS;
            cmdReadyR  <= cmdReadyNextS;
            rspValidR  <= rspValidNextS;
            rspDataR   <= rspDataNextS;
            rspErrR    <= rspErrNextS;
            writeEnR   <= writeEnNextS;
            writeRegR  <= writeRegNextS;
            writeDataR <= writeDataNextS;
            readRegR   <= readRegNextS;
        end
    end

    assign cmd_ready    = cmdReadyR;
    assign rsp_valid    = rspValidR;
    assign rsp_data     = rspDataR;
    assign rsp_err      = rspErrR;
    assign rf_writeEn   = writeEnR;
    assign rf_writeReg  = writeRegR;
    assign rf_writeData = writeDataR;
    assign rf_readRegA  = readRegR;
    assign rf_readRegB  = readRegR;

endmodule
